// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared state/mode encodings and ID width helper for the interrupt controller
package irq_ctrl_pkg;
  typedef enum logic {
    IRQ_STATE_IDLE = 1'b0,
    IRQ_STATE_BUSY = 1'b1
  } irq_state_e;
  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_EDGE  = 1'b1;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index priority encoder with valid flag
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] id,
  output logic            valid
);
  // scan from the top so the lowest set index is written last
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) id = ID_W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchronizer for one asynchronous line, no reset
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  // shift the raw line through the metastability chain
  always_ff @(posedge clk) sync_q <= {sync_q[STAGES-2:0], d};
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: N-channel edge/level interrupt controller with claim/complete handshake
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W = id_width(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_enable,
  input  logic [N_IRQ-1:0] irq_edge_mode,
  input  logic             claim,
  input  logic             complete,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [ID_W-1:0]  claimed_id,
  output logic             busy,
  output logic [N_IRQ-1:0] pending
);
  logic [N_IRQ-1:0] s, p_q, pend_q, pend_d, masked;
  logic [ID_W-1:0]  sel_id, claimed_id_q, claimed_id_d;
  logic             sel_valid, accept;
  irq_state_e       state_q, state_d;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .d(irq[i]), .q(s[i]));
  end

  assign masked = pend_q & irq_enable;

  irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_enc (.req(masked), .id(sel_id), .valid(sel_valid));

  assign irq_req    = (state_q == IRQ_STATE_IDLE) && sel_valid;
  assign accept     = irq_req && claim;
  assign irq_id     = sel_id;
  assign claimed_id = claimed_id_q;
  assign busy       = state_q == IRQ_STATE_BUSY;
  assign pending    = pend_q;

  // edge channels set on a rising edge (beating a same-cycle claim clear); level channels track the line
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_IRQ; i++)
      pend_d[i] = irq_edge_mode[i] == IRQ_MODE_EDGE
                ? (s[i] & ~p_q[i]) | (pend_q[i] & ~(accept && sel_id == ID_W'(i)))
                : s[i];
  end

  // claim only leaves IDLE when a request is shown; complete only leaves BUSY
  always_comb begin
    state_d      = state_q == IRQ_STATE_BUSY ? (complete ? IRQ_STATE_IDLE : IRQ_STATE_BUSY)
                                             : (accept ? IRQ_STATE_BUSY : IRQ_STATE_IDLE);
    claimed_id_d = accept ? sel_id : claimed_id_q;
  end

  // edge history, pending bits and handshake state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q          <= '0;
      pend_q       <= '0;
      state_q      <= IRQ_STATE_IDLE;
      claimed_id_q <= '0;
    end else begin
      p_q          <= s;
      pend_q       <= pend_d;
      state_q      <= state_d;
      claimed_id_q <= claimed_id_d;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_irq_ctrl;
  localparam int N = 8;
  localparam int SYNC = 2;
  localparam int IW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] irq = '0, en = '0, mode = '0;
  logic claim = 1'b0, complete = 1'b0;
  logic irq_req, busy;
  logic [IW-1:0] irq_id, claimed_id;
  logic [N-1:0] pending;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_IRQ(N), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_enable(en), .irq_edge_mode(mode),
    .claim(claim), .complete(complete), .irq_req(irq_req), .irq_id(irq_id),
    .claimed_id(claimed_id), .busy(busy), .pending(pending)
  );

  // behavioural model: raw lines delayed SYNC samples, then the latch/claim rules
  bit [N-1:0] m_sh [SYNC];
  bit [N-1:0] m_p, m_pend, m_s, m_msk;
  bit m_busy, m_take;
  int m_cid, m_id;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(negedge rst_n) begin
    m_p = '0; m_pend = '0; m_busy = 0; m_cid = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p = '0; m_pend = '0; m_busy = 0; m_cid = 0;
    end else begin
      m_s = m_sh[SYNC-1];
      m_msk = m_pend & en;
      m_id = lowest(m_msk);
      m_take = !m_busy && m_msk != 0 && claim;
      for (int i = 0; i < N; i++)
        m_pend[i] = mode[i] ? ((m_s[i] && !m_p[i]) || (m_pend[i] && !(m_take && m_id == i))) : m_s[i];
      if (m_busy) m_busy = !complete;
      else if (m_take) begin m_busy = 1; m_cid = m_id; end
      m_p = m_s;
    end
    for (int k = SYNC - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
    m_sh[0] = irq;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 0; irq = '0; en = '0; mode = '0;
    tick(3);
    checks += 5;
    if (irq_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", irq_req); end
    if (irq_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (claimed_id !== '0) begin failures++; $display("FAIL reset_cid got=%0d exp=0", claimed_id); end
    if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%h exp=00", pending); end
    rst_n = 1;
    tick(3);
    checks += 2;
    if (pending !== '0) begin failures++; $display("FAIL post_reset_pending got=%h exp=00", pending); end
    if (irq_req !== 1'b0) begin failures++; $display("FAIL post_reset_req got=%b exp=0", irq_req); end
  endtask

  task automatic test_edge_single();
    mode = 8'hFF; en = 8'hFF;
    irq = 8'h08; tick(1); irq = '0;
    tick(1);
    checks++;
    if (irq_req !== 1'b0) begin failures++; $display("FAIL edge_early_req got=%b exp=0", irq_req); end
    tick(1);
    checks += 2;
    if (irq_req !== 1'b1) begin failures++; $display("FAIL edge_latency_req got=%b exp=1", irq_req); end
    if (irq_id !== 3'd3) begin failures++; $display("FAIL edge_id got=%0d exp=3", irq_id); end
    claim = 1; tick(1); claim = 0;
    checks += 4;
    if (busy !== 1'b1) begin failures++; $display("FAIL edge_claim_busy got=%b exp=1", busy); end
    if (claimed_id !== 3'd3) begin failures++; $display("FAIL edge_claim_cid got=%0d exp=3", claimed_id); end
    if (pending[3] !== 1'b0) begin failures++; $display("FAIL edge_claim_pend3 got=%b exp=0", pending[3]); end
    if (irq_req !== 1'b0) begin failures++; $display("FAIL edge_busy_req got=%b exp=0", irq_req); end
    complete = 1; tick(1); complete = 0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL edge_complete_busy got=%b exp=0", busy); end
    if (irq_req !== 1'b0) begin failures++; $display("FAIL edge_complete_req got=%b exp=0", irq_req); end
  endtask

  task automatic test_priority();
    en = 8'hFB;
    irq = 8'h24; tick(1); irq = '0; tick(3);
    checks += 3;
    if (irq_req !== 1'b1) begin failures++; $display("FAIL prio_req got=%b exp=1", irq_req); end
    if (irq_id !== 3'd5) begin failures++; $display("FAIL prio_masked_id got=%0d exp=5", irq_id); end
    if (pending !== 8'h24) begin failures++; $display("FAIL prio_pending got=%h exp=24", pending); end
    en = 8'hFF; #1;
    checks++;
    if (irq_id !== 3'd2) begin failures++; $display("FAIL prio_unmask_id got=%0d exp=2", irq_id); end
    claim = 1; tick(1); claim = 0;
    checks++;
    if (claimed_id !== 3'd2) begin failures++; $display("FAIL prio_cid got=%0d exp=2", claimed_id); end
    complete = 1; tick(1); complete = 0;
    checks += 2;
    if (irq_req !== 1'b1) begin failures++; $display("FAIL prio_next_req got=%b exp=1", irq_req); end
    if (irq_id !== 3'd5) begin failures++; $display("FAIL prio_next_id got=%0d exp=5", irq_id); end
    claim = 1; tick(1); claim = 0; complete = 1; tick(1); complete = 0;
    checks++;
    if (pending !== '0) begin failures++; $display("FAIL prio_drain got=%h exp=00", pending); end
  endtask

  task automatic test_level();
    mode = 8'hFD; en = 8'hFF;
    irq = 8'h02; tick(3);
    checks += 2;
    if (irq_req !== 1'b1) begin failures++; $display("FAIL level_req got=%b exp=1", irq_req); end
    if (irq_id !== 3'd1) begin failures++; $display("FAIL level_id got=%0d exp=1", irq_id); end
    claim = 1; tick(1); claim = 0;
    checks++;
    if (pending[1] !== 1'b1) begin failures++; $display("FAIL level_claim_pend got=%b exp=1", pending[1]); end
    complete = 1; tick(1); complete = 0;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL level_complete_busy got=%b exp=0", busy); end
    if (irq_req !== 1'b1) begin failures++; $display("FAIL level_rereq got=%b exp=1", irq_req); end
    if (irq_id !== 3'd1) begin failures++; $display("FAIL level_rereq_id got=%0d exp=1", irq_id); end
    claim = 1; tick(1); claim = 0;
    irq = '0; tick(3);
    complete = 1; tick(1); complete = 0;
    tick(3);
    checks += 2;
    if (irq_req !== 1'b0) begin failures++; $display("FAIL level_drop_req got=%b exp=0", irq_req); end
    if (pending !== '0) begin failures++; $display("FAIL level_drop_pend got=%h exp=00", pending); end
    mode = 8'hFF;
  endtask

  task automatic test_simultaneous();
    irq = 8'h10; tick(1); irq = '0; tick(3);
    checks++;
    if (irq_id !== 3'd4 || irq_req !== 1'b1) begin failures++; $display("FAIL simul_first req=%b id=%0d exp req=1 id=4", irq_req, irq_id); end
    irq = 8'h10; tick(1); irq = '0; tick(1);
    claim = 1; tick(1); claim = 0;
    checks += 2;
    if (busy !== 1'b1 || claimed_id !== 3'd4) begin failures++; $display("FAIL simul_claim busy=%b cid=%0d exp busy=1 cid=4", busy, claimed_id); end
    if (pending[4] !== 1'b1) begin failures++; $display("FAIL simul_edge_kept got=%b exp=1", pending[4]); end
    complete = 1; tick(1); complete = 0;
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd4) begin failures++; $display("FAIL simul_rereq req=%b id=%0d exp req=1 id=4", irq_req, irq_id); end
    claim = 1; tick(1);
    complete = 1; tick(1); claim = 0; complete = 0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL simul_both_busy got=%b exp=0", busy); end
    if (irq_req !== 1'b0) begin failures++; $display("FAIL simul_both_req got=%b exp=0", irq_req); end
  endtask

  task automatic test_ignored();
    claim = 1; tick(1); claim = 0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL ign_claim_busy got=%b exp=0", busy); end
    if (pending !== '0) begin failures++; $display("FAIL ign_claim_pend got=%h exp=00", pending); end
    complete = 1; tick(1); complete = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ign_complete_busy got=%b exp=0", busy); end
    en = 8'hBF;
    irq = 8'h40; tick(1); irq = '0; tick(3);
    claim = 1; tick(1); claim = 0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL ign_masked_busy got=%b exp=0", busy); end
    if (pending !== 8'h40) begin failures++; $display("FAIL ign_masked_pend got=%h exp=40", pending); end
    en = 8'hFF; #1;
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd6) begin failures++; $display("FAIL ign_enable req=%b id=%0d exp req=1 id=6", irq_req, irq_id); end
    claim = 1; tick(1); claim = 0; complete = 1; tick(1); complete = 0;
  endtask

  task automatic test_reset_mid();
    irq = 8'h81; tick(1); irq = '0; tick(3);
    claim = 1; tick(1); claim = 0;
    irq = 8'h01; tick(1); irq = '0; tick(3);
    checks++;
    if (pending !== 8'h81 || busy !== 1'b1) begin failures++; $display("FAIL mid_setup pend=%h busy=%b exp pend=81 busy=1", pending, busy); end
    #1; rst_n = 0; #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (irq_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%b exp=0", irq_req); end
    if (pending !== '0) begin failures++; $display("FAIL mid_pend got=%h exp=00", pending); end
    if (claimed_id !== '0) begin failures++; $display("FAIL mid_cid got=%0d exp=0", claimed_id); end
    tick(2); rst_n = 1; tick(4);
    checks++;
    if (irq_req !== 1'b0 || pending !== '0) begin failures++; $display("FAIL mid_after req=%b pend=%h exp req=0 pend=00", irq_req, pending); end
    irq = 8'h04; tick(1); irq = '0; tick(3);
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 3'd2) begin failures++; $display("FAIL mid_new_edge req=%b id=%0d exp req=1 id=2", irq_req, irq_id); end
    claim = 1; tick(1); claim = 0; complete = 1; tick(1); complete = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_msk;
    for (int c = 0; c < 400; c++) begin
      irq = irq ^ N'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) en = N'($urandom);
      if ($urandom_range(0, 15) == 0) mode = N'($urandom);
      claim = $urandom_range(0, 2) == 0;
      complete = $urandom_range(0, 3) == 0;
      #1;
      e_msk = m_pend & en;
      checks += 5;
      if (irq_req !== (!m_busy && e_msk != 0)) begin failures++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, irq_req, !m_busy && e_msk != 0); end
      if (irq_id !== IW'(lowest(e_msk))) begin failures++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, irq_id, lowest(e_msk)); end
      if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
      if (claimed_id !== IW'(m_cid)) begin failures++; $display("FAIL rnd_cid c=%0d got=%0d exp=%0d", c, claimed_id, m_cid); end
      if (pending !== m_pend) begin failures++; $display("FAIL rnd_pend c=%0d got=%h exp=%h", c, pending, m_pend); end
      tick(1);
    end
    claim = 0; complete = 0;
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_priority();
    test_level();
    test_simultaneous();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
